// File: rtl/regfile_access_arbiter.sv
// Two-requester round-robin front end for a single register-file read/write port
// pair. In IDLE a winner is picked combinationally. Its command is registered and
// issued to the register file for one cycle. Read data is returned one cycle later
// with a valid pulse.
module regfile_access_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int PROTECT_R0 = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rf_read_enable,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state;
    logic                  ptr;      // 0: A favoured on a tie, 1: B favoured
    logic                  cmd_id;   // 0: A owns the command in flight, 1: B
    logic                  pick_b;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  wr_block;

    // B wins when it is the only requester or when both ask and the pointer favours B
    assign pick_b    = req_b && (!req_a || ptr);
    assign sel_we    = pick_b ? we_b    : we_a;
    assign sel_addr  = pick_b ? addr_b  : addr_a;
    assign sel_wdata = pick_b ? wdata_b : wdata_a;
    assign wr_block  = (PROTECT_R0 != 0) && (sel_addr == '0);

    // Grants are only offered in IDLE; gated by reset so outputs are 0 while held in reset
    assign gnt_a = rst && (state == IDLE) && req_a && !pick_b;
    assign gnt_b = rst && (state == IDLE) && pick_b;

    // Arbitration FSM with registered register-file controls and read return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ptr             <= 1'b0;
            cmd_id          <= 1'b0;
            rvalid_a        <= 1'b0;
            rvalid_b        <= 1'b0;
            rdata_a         <= '0;
            rdata_b         <= '0;
            rf_read_enable  <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_read_addr    <= '0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        cmd_id <= pick_b;
                        ptr    <= ~pick_b;
                        if (sel_we) begin
                            // A protected r0 write is still accepted, it just never strobes
                            rf_write_enable <= !wr_block;
                            rf_write_addr   <= sel_addr;
                            rf_write_data   <= sel_wdata;
                        end else begin
                            rf_read_enable <= 1'b1;
                            rf_read_addr   <= sel_addr;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    rf_read_enable  <= 1'b0;
                    rf_write_enable <= 1'b0;
                    if (rf_read_enable) begin
                        if (cmd_id) begin
                            rdata_b  <= rf_read_data;
                            rvalid_b <= 1'b1;
                        end else begin
                            rdata_a  <= rf_read_data;
                            rvalid_a <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    rvalid_a <= 1'b0;
                    rvalid_b <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter: a behavioural register file sits on
// the rf_* port, test code pushes expected grants/writes/read data into queues and
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_regfile_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we_a = 1'b0, we_b = 1'b0;
    logic [2:0]  addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [15:0] rdata_a, rdata_b;
    logic        rf_read_enable, rf_write_enable;
    logic [2:0]  rf_read_addr, rf_write_addr;
    logic [15:0] rf_write_data, rf_read_data;

    regfile_access_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .PROTECT_R0(1)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rf_read_enable(rf_read_enable), .rf_write_enable(rf_write_enable),
        .rf_read_addr(rf_read_addr), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural register file; read data is garbage unless the read is enabled
    logic [15:0] rf_mem [0:7];
    initial for (int i = 0; i < 8; i++) rf_mem[i] = 16'h0000;
    always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
    assign rf_read_data = rf_read_enable ? rf_mem[rf_read_addr] : 16'hDEAD;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] qa[$];   // expected rdata_a values
    logic [15:0] qb[$];   // expected rdata_b values
    bit          gq[$];   // expected grant order, 0 = A, 1 = B
    logic [18:0] wq[$];   // expected register writes {addr, data}

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, rf_read_enable,
                 rf_write_enable, rf_read_addr, rf_write_addr, rf_write_data}, 64'h0);
    endtask

    // Issue one command and hold it until granted; returns cycles spent waiting
    task automatic do_req(input bit id, input bit we, input logic [2:0] a,
                          input logic [15:0] d, output int waited);
        bit got = 1'b0;
        waited = 0;
        if (!id) begin we_a = we; addr_a = a; wdata_a = d; req_a = 1'b1; end
        else     begin we_b = we; addr_b = a; wdata_b = d; req_b = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? gnt_b : gnt_a) begin got = 1'b1; break; end
            waited++;
        end
        if (!got) chk(id ? "timeout_gnt_b" : "timeout_gnt_a", 0, 1);
        @(posedge clk); #1;
        if (!id) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents grants, writes or read data
    always @(negedge clk) begin
        if (rf_read_enable && rf_write_enable) chk("rf_enable_overlap", 1, 0);
        if (gnt_a && gnt_b) chk("gnt_both", 1, 0);
        else if (gnt_a || gnt_b) begin
            if (gq.size() == 0) chk("gnt_unexpected", {gnt_a, gnt_b}, 0);
            else chk("gnt_order_is_b", gnt_b, gq.pop_front());
        end
        if (rf_write_enable) begin
            if (wq.size() == 0) chk("rf_write_unexpected", {rf_write_addr, rf_write_data}, 0);
            else chk("rf_write_addr_data", {rf_write_addr, rf_write_data}, wq.pop_front());
        end
        if (rvalid_a) begin
            if (qa.size() == 0) chk("rvalid_a_unexpected", 1, 0);
            else chk("rdata_a", rdata_a, qa.pop_front());
        end
        if (rvalid_b) begin
            if (qb.size() == 0) chk("rvalid_b_unexpected", 1, 0);
            else chk("rdata_b", rdata_b, qb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    int w, wa, wb, w5;

    initial begin
        // Reset state
        idle(2);
        chk_zero("reset_outputs");
        rst = 1'b1;
        idle(1);

        // A writes r5 then reads it back; rvalid two cycles after the read grant
        gq.push_back(0); gq.push_back(0);
        wq.push_back({3'd5, 16'h1234});
        qa.push_back(16'h1234);
        do_req(0, 1, 3'd5, 16'h1234, w);
        do_req(0, 0, 3'd5, 16'h0000, w);
        @(negedge clk); chk("t2_rvalid_a_n1", rvalid_a, 0);
        @(negedge clk); chk("t2_rvalid_a_n2", rvalid_a, 1);
        chk("t2_rdata_a", rdata_a, 16'h1234);
        idle(1);

        // Reset mid-RESP abandons the read and clears every output at once
        gq.push_back(0);
        do_req(0, 0, 3'd5, 16'h0000, w);
        @(posedge clk); #1;
        chk("t1_in_resp_rvalid_a", rvalid_a, 1);
        rst = 1'b0;
        #1;
        chk_zero("t1_async_reset_outputs");
        idle(2);
        rst = 1'b1;
        idle(1);
        gq.push_back(0); gq.push_back(1);
        qa.push_back(16'h1234); qb.push_back(16'h0000);
        fork
            do_req(0, 0, 3'd5, 16'h0000, wa);
            do_req(1, 0, 3'd4, 16'h0000, wb);
        join
        chk("t1_a_first_no_wait", wa, 0);
        idle(3);

        // Preload r1..r3 (grants A, B, B; pointer returns to A)
        gq.push_back(0); gq.push_back(1); gq.push_back(1);
        wq.push_back({3'd1, 16'h1111});
        wq.push_back({3'd2, 16'h2222});
        wq.push_back({3'd3, 16'h3333});
        do_req(0, 1, 3'd1, 16'h1111, w);
        do_req(1, 1, 3'd2, 16'h2222, w);
        do_req(1, 1, 3'd3, 16'h3333, w);
        idle(1);

        // Both requesters stream four reads each: grants alternate A,B,...
        for (int i = 0; i < 4; i++) begin gq.push_back(0); gq.push_back(1); end
        qa.push_back(16'h1111); qa.push_back(16'h1234); qa.push_back(16'h1111); qa.push_back(16'h1234);
        qb.push_back(16'h2222); qb.push_back(16'h1234); qb.push_back(16'h2222); qb.push_back(16'h1234);
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(0, 0, (i % 2 == 0) ? 3'd1 : 3'd5, 16'h0, wa);
            end
            begin
                for (int j = 0; j < 4; j++) do_req(1, 0, (j % 2 == 0) ? 3'd2 : 3'd5, 16'h0, wb);
            end
        join
        idle(3);

        // Protected r0: write is granted but never strobed, read returns 0
        gq.push_back(0); gq.push_back(0);
        qa.push_back(16'h0000);
        do_req(0, 1, 3'd0, 16'hFFFF, w);
        do_req(0, 0, 3'd0, 16'h0000, w);
        idle(3);
        chk("t4_rdata_a_r0", rdata_a, 16'h0000);

        // B reads r3 while A raises req during ISSUE; A waits for the next IDLE
        gq.push_back(1); gq.push_back(0);
        qb.push_back(16'h3333); qa.push_back(16'h1111);
        fork
            do_req(1, 0, 3'd3, 16'h0000, wb);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (gnt_b) break;
                end
                @(posedge clk); #1;
                do_req(0, 0, 3'd1, 16'h0000, w5);
                chk("t5_gnt_a_deferred_cycles", w5, 2);
            end
        join
        idle(3);
        chk("t5_rdata_b_held", rdata_b, 16'h3333);
        chk("t5_rdata_a", rdata_a, 16'h1111);

        // Back-to-back write then read of r7 by B
        gq.push_back(1); gq.push_back(1);
        wq.push_back({3'd7, 16'h00AA});
        qb.push_back(16'h00AA);
        do_req(1, 1, 3'd7, 16'h00AA, w);
        do_req(1, 0, 3'd7, 16'h0000, w);
        idle(3);
        chk("t6_rdata_b", rdata_b, 16'h00AA);

        // Everything expected must have been observed
        chk("left_qa", qa.size(), 0);
        chk("left_qb", qb.size(), 0);
        chk("left_gq", gq.size(), 0);
        chk("left_wq", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
